// File: rtl/oric_tap_pkg.sv
// rtl/oric_tap_pkg.sv - shared types, frame constants and cell-bit helper for the Oric TAP player
//
// Purpose : player FSM states, cell phases, frame length and the function that
//           picks the level of a given cell within a byte frame.
// Ports   : none (package).
package oric_tap_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } tap_state_t;

    typedef enum logic {
        PH_HI = 1'b0,
        PH_LO = 1'b1
    } cell_phase_t;

    localparam int STOP_BITS_DEF = 4;

    // start cell + 8 data cells + parity cell + stop cells
    function automatic int frame_cells(input int stop_bits);
        return 10 + stop_bits;
    endfunction

    localparam int FRAME_CELLS = frame_cells(STOP_BITS_DEF);

    // Level of cell idx in the frame: 0 = start, 1..8 = data LSB first,
    // 9 = odd parity, anything later is a stop cell.
    function automatic logic cell_bit(input logic [7:0] data, input int idx);
        if (idx == 0) begin
            return 1'b0;
        end else if (idx <= 8) begin
            return data[3'(idx - 1)];
        end else if (idx == 9) begin
            return ~^data;
        end else begin
            return 1'b1;
        end
    endfunction

endpackage

// File: rtl/oric_tap_bitgen.sv
// rtl/oric_tap_bitgen.sv - one-cell waveform generator (high half-cell, then short or long low)
//
// Purpose : while run=1, shapes the current cell bit into tape_out and pulses
//           cell_done on the tick that ends the low phase.
// Ports   : clk, rst_n (async active-low), run (cell sequencing enabled),
//           tick (timing strobe, already gated), bit_in (cell value),
//           tape_out (cassette level), cell_done (combinational end-of-cell pulse).
module oric_tap_bitgen
    import oric_tap_pkg::*;
#(
    parameter int T_HALF = 208,
    parameter int T_LONG = 416
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic tick,
    input  logic bit_in,
    output logic tape_out,
    output logic cell_done
);

    localparam int CW = $clog2(T_LONG + 1);

    cell_phase_t   phase_q;
    logic [CW-1:0] cnt_q;
    logic          out_q;
    logic [CW-1:0] lim;
    logic          reach;

    // high phase is always a half cell; low phase length depends on the bit
    assign lim       = (phase_q == PH_HI || bit_in) ? CW'(T_HALF) : CW'(T_LONG);
    assign reach     = tick && (cnt_q == lim - CW'(1));
    assign cell_done = run && reach && (phase_q == PH_LO);
    assign tape_out  = out_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= PH_HI;
            cnt_q   <= '0;
            out_q   <= 1'b1;
        end else if (!run) begin
            phase_q <= PH_HI;
            cnt_q   <= '0;
            out_q   <= 1'b1;
        end else if (tick) begin
            if (reach) begin
                cnt_q   <= '0;
                phase_q <= (phase_q == PH_HI) ? PH_LO : PH_HI;
                out_q   <= (phase_q == PH_LO);
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/oric_tap_player.sv
// rtl/oric_tap_player.sv - plays a .TAP byte image as an Oric fast-format cassette waveform
//
// Purpose : fetches bytes over a read handshake and serialises each as
//           start/8 data/odd parity/STOP_BITS stop cells on tape_out.
// Ports   : CLK_IN, RESETn (async active-low), ENA_1MHZ (timing strobe),
//           start/stop pulses, tap_len (sampled on start), remote (motor relay),
//           buf_rd/buf_addr/buf_data/buf_valid (byte fetch), tape_out (K7_TAPEIN),
//           busy, tape_addr (byte being serialised), tape_complete (sticky).
// Macro   : TAP_REMOTE_GATE_EN - when defined, remote=0 freezes cell timing.
module oric_tap_player
    import oric_tap_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int T_HALF    = 208,
    parameter int T_LONG    = 416,
    parameter int STOP_BITS = STOP_BITS_DEF
) (
    input  logic              CLK_IN,
    input  logic              RESETn,
    input  logic              ENA_1MHZ,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W-1:0] tap_len,
    input  logic              remote,
    output logic              buf_rd,
    output logic [ADDR_W-1:0] buf_addr,
    input  logic [7:0]        buf_data,
    input  logic              buf_valid,
    output logic              tape_out,
    output logic              busy,
    output logic [ADDR_W-1:0] tape_addr,
    output logic              tape_complete
);

    localparam int                FRAME_N   = frame_cells(STOP_BITS);
    localparam int                CIW       = $clog2(FRAME_N);
    localparam logic [CIW-1:0]    LAST_CELL = CIW'(FRAME_N - 1);

    tap_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] tape_addr_q, tape_addr_d;
    logic [7:0]        byte_q, byte_d;
    logic [CIW-1:0]    cell_q, cell_d;
    logic              complete_q, complete_d;
    logic              tick, run, cell_done, cur_bit;

`ifdef TAP_REMOTE_GATE_EN
    // FETCH is untimed, so only the cell timers see the frozen strobe
    assign tick = ENA_1MHZ & remote;
`else
    logic unused_remote;
    assign unused_remote = remote;
    assign tick          = ENA_1MHZ;
`endif

    // stop dominates: the cell generator is parked in the same cycle
    assign run     = (state_q == SEND) && !stop;
    assign cur_bit = cell_bit(byte_q, int'(cell_q));

    oric_tap_bitgen #(
        .T_HALF (T_HALF),
        .T_LONG (T_LONG)
    ) u_bitgen (
        .clk       (CLK_IN),
        .rst_n     (RESETn),
        .run       (run),
        .tick      (tick),
        .bit_in    (cur_bit),
        .tape_out  (tape_out),
        .cell_done (cell_done)
    );

    assign buf_rd        = (state_q == FETCH);
    assign buf_addr      = addr_q;
    assign busy          = (state_q == FETCH) || (state_q == SEND);
    assign tape_addr     = tape_addr_q;
    assign tape_complete = complete_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        tape_addr_d = tape_addr_q;
        byte_d      = byte_q;
        cell_d      = cell_q;
        complete_d  = complete_q;
        if (stop) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (tap_len == '0) begin
                            complete_d = 1'b1;
                        end else begin
                            complete_d = 1'b0;
                            len_d      = tap_len;
                            addr_d     = '0;
                            state_d    = FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (buf_valid) begin
                        byte_d      = buf_data;
                        tape_addr_d = addr_q;
                        cell_d      = '0;
                        state_d     = SEND;
                    end
                end
                SEND: begin
                    if (cell_done) begin
                        if (cell_q == LAST_CELL) begin
                            // len <= 2^ADDR_W-1, so addr+1 cannot wrap
                            addr_d = addr_q + ADDR_W'(1);
                            if (addr_q == len_q - ADDR_W'(1)) begin
                                complete_d = 1'b1;
                                state_d    = DONE;
                            end else begin
                                state_d = FETCH;
                            end
                        end else begin
                            cell_d = cell_q + CIW'(1);
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK_IN or negedge RESETn) begin
        if (!RESETn) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            tape_addr_q <= '0;
            byte_q      <= '0;
            cell_q      <= '0;
            complete_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            tape_addr_q <= tape_addr_d;
            byte_q      <= byte_d;
            cell_q      <= cell_d;
            complete_q  <= complete_d;
        end
    end

endmodule

// File: tb/tb_oric_tap_player.sv
// tb/tb_oric_tap_player.sv - self-checking bench for oric_tap_player
module tb_oric_tap_player;

    localparam int AW     = 16;
    localparam int TH     = 10;
    localparam int TL     = 20;
    localparam int SB     = 4;
    localparam int FR     = 10 + SB;
    localparam int BUDGET = 4000;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          ena       = 1'b0;
    logic          start     = 1'b0;
    logic          stop      = 1'b0;
    logic          remote    = 1'b1;
    logic [AW-1:0] tap_len   = '0;
    logic          buf_valid = 1'b0;
    logic [7:0]    buf_data  = 8'h00;
    logic          buf_rd, tape_out, busy, tape_complete;
    logic [AW-1:0] buf_addr, tape_addr;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mem [0:7];
    int         rsp_delay = 0;
    int         wait_cnt  = 0;
    int         unstable  = 0;
    logic [AW-1:0] last_addr = '0;
    int         rd_addrs[$];

    // waveform monitor state
    int   lows[$];
    int   highs[$];
    int   hi_cnt     = 0;
    int   lo_cnt     = 0;
    int   tick_total = 0;
    int   gap_low    = 0;
    logic lvl        = 1'b1;
    logic pend_ena   = 1'b0;
    logic pend_gate  = 1'b1;

    oric_tap_player #(
        .ADDR_W    (AW),
        .T_HALF    (TH),
        .T_LONG    (TL),
        .STOP_BITS (SB)
    ) dut (
        .CLK_IN        (clk),
        .RESETn        (rst_n),
        .ENA_1MHZ      (ena),
        .start         (start),
        .stop          (stop),
        .tap_len       (tap_len),
        .remote        (remote),
        .buf_rd        (buf_rd),
        .buf_addr      (buf_addr),
        .buf_data      (buf_data),
        .buf_valid     (buf_valid),
        .tape_out      (tape_out),
        .busy          (busy),
        .tape_addr     (tape_addr),
        .tape_complete (tape_complete)
    );

    initial begin
        forever begin
            #5 clk = 1'b1;
            #2 ena = ($urandom_range(0, 1) == 1);
            #3 clk = 1'b0;
        end
    end

    // Measures each low and high phase in counted strobe ticks. Inputs seen at a
    // negedge are the ones the following posedge consumes, so they are held
    // pending and accounted one negedge later against the pre-edge level.
    always @(negedge clk) begin
        if (pend_ena) begin
            tick_total++;
            if (pend_gate) begin
                if (lvl) hi_cnt++;
                else     lo_cnt++;
            end
        end
        if (lvl && !tape_out) begin
            highs.push_back(hi_cnt);
            hi_cnt = 0;
            lo_cnt = 0;
        end else if (!lvl && tape_out) begin
            lows.push_back(lo_cnt);
            lo_cnt = 0;
            hi_cnt = 0;
        end
        if (buf_rd && !tape_out) gap_low++;
        lvl      = tape_out;
        pend_ena = ena;
`ifdef TAP_REMOTE_GATE_EN
        pend_gate = remote;
`else
        pend_gate = 1'b1;
`endif
    end

    // byte buffer: answers each request after rsp_delay cycles
    always @(posedge clk) begin
        #1;
        if (buf_valid) begin
            buf_valid = 1'b0;
        end else if (buf_rd) begin
            if (wait_cnt > 0 && buf_addr !== last_addr) unstable++;
            last_addr = buf_addr;
            if (wait_cnt >= rsp_delay) begin
                buf_data  = mem[buf_addr[2:0]];
                buf_valid = 1'b1;
                rd_addrs.push_back(int'(buf_addr));
                wait_cnt  = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int len);
        @(posedge clk); #1;
        tap_len = AW'(len);
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
    endtask

    task automatic pulse_stop();
        @(posedge clk); #1;
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
    endtask

    task automatic wait_lows(input int n, input string tag);
        int k = 0;
        while (lows.size() < n && k < BUDGET) begin
            @(posedge clk); #1;
            k++;
        end
        check({tag, "_timeout"}, lows.size() >= n, 1);
    endtask

    task automatic wait_level(input logic v, input string tag);
        int k = 0;
        while (tape_out !== v && k < BUDGET) begin
            @(posedge clk); #1;
            k++;
        end
        check({tag, "_timeout"}, tape_out, v);
    endtask

    task automatic wait_ticks(input int n);
        int t0 = tick_total;
        int k  = 0;
        while (tick_total < t0 + n && k < BUDGET) begin
            @(posedge clk); #1;
            k++;
        end
        check("tick_wait_timeout", tick_total >= t0 + n, 1);
    endtask

    task automatic wait_complete(input string tag);
        int k = 0;
        while (tape_complete !== 1'b1 && k < BUDGET) begin
            @(posedge clk); #1;
            k++;
        end
        check({tag, "_complete"}, tape_complete, 1);
        check({tag, "_busy_done"}, busy, 0);
        check({tag, "_tape_idle"}, tape_out, 1);
    endtask

    // Expected cells from the framing rules: start 0, data LSB first,
    // parity making the count of ones odd, then stop ones.
    task automatic verify_frame(input int base, input int k, input int addr, input logic [7:0] b);
        int bits[FR];
        int idx;
        bits[0] = 0;
        for (int i = 0; i < 8; i++) bits[i + 1] = (int'(b) >> i) & 1;
        bits[9] = ($countones(b) % 2 == 0) ? 1 : 0;
        for (int i = 10; i < FR; i++) bits[i] = 1;
        for (int c = 0; c < FR; c++) begin
            idx = base + k * FR + c;
            wait_lows(idx + 1, "frame");
            if (lows.size() > idx) begin
                check($sformatf("low_f%0d_c%0d", k, c), lows[idx], (bits[c] == 1) ? TH : TL);
                if (c == 0) begin
                    check($sformatf("tape_addr_f%0d", k), tape_addr, addr);
                    check($sformatf("high_first_f%0d", k), highs[idx] >= TH, 1);
                end else begin
                    check($sformatf("high_f%0d_c%0d", k, c), highs[idx], TH);
                end
            end
        end
    endtask

    initial begin
        int base;
        int a0;

        for (int i = 0; i < 8; i++) mem[i] = 8'($urandom);

        // reset values
        rst_n = 1'b0;
        cycles(3);
        check("rst_tape_out", tape_out, 1);
        check("rst_busy", busy, 0);
        check("rst_buf_rd", buf_rd, 0);
        check("rst_buf_addr", buf_addr, 0);
        check("rst_tape_addr", tape_addr, 0);
        check("rst_complete", tape_complete, 0);
        rst_n = 1'b1;
        cycles(2);

        // empty image completes at once without any fetch
        a0 = rd_addrs.size();
        pulse_start(0);
        check("len0_complete", tape_complete, 1);
        check("len0_busy", busy, 0);
        cycles(20);
        check("len0_no_fetch", rd_addrs.size(), a0);
        check("len0_buf_rd", buf_rd, 0);

        // single byte 8'h16 answered in the request's first cycle
        mem[0]    = 8'h16;
        rsp_delay = 0;
        base      = lows.size();
        a0        = rd_addrs.size();
        pulse_start(1);
        check("t1_start_clears_complete", tape_complete, 0);
        check("t1_busy", busy, 1);
        verify_frame(base, 0, 0, 8'h16);
        wait_complete("t1");
        check("t1_fetch_count", rd_addrs.size() - a0, 1);

        // three random bytes with slow fetches; a start mid-run is ignored
        for (int i = 0; i < 3; i++) mem[i] = 8'($urandom);
        rsp_delay = 5;
        base      = lows.size();
        a0        = rd_addrs.size();
        pulse_start(3);
        check("t3_start_clears_complete", tape_complete, 0);
        cycles(30);
        pulse_start(1);
        check("t3_busy_after_restart", busy, 1);
        for (int k = 0; k < 3; k++) verify_frame(base, k, k, mem[k]);
        wait_complete("t3");
        check("t3_fetch_count", rd_addrs.size() - a0, 3);
        for (int i = 0; i < 3; i++) begin
            if (rd_addrs.size() > a0 + i) check($sformatf("t3_addr%0d", i), rd_addrs[a0 + i], i);
        end

        // stop during data cell 4 of the second byte, then replay from 0
        rsp_delay = 1;
        base      = lows.size();
        pulse_start(3);
        verify_frame(base, 0, 0, mem[0]);
        wait_lows(base + FR + 5, "t4_mid");
        pulse_stop();
        check("t4_busy", busy, 0);
        check("t4_tape_out", tape_out, 1);
        check("t4_buf_rd", buf_rd, 0);
        check("t4_complete_kept", tape_complete, 0);
        cycles(60);
        check("t4_still_idle", busy, 0);
        base = lows.size();
        a0   = rd_addrs.size();
        pulse_start(2);
        verify_frame(base, 0, 0, mem[0]);
        if (rd_addrs.size() > a0) check("t4_replay_addr", rd_addrs[a0], 0);

        // reset in a low phase of the second byte
        wait_lows(base + FR + 3, "t5_mid");
        wait_level(1'b0, "t5_low");
        rst_n = 1'b0;
        #1;
        check("t5_rst_tape_out", tape_out, 1);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_buf_rd", buf_rd, 0);
        check("t5_rst_buf_addr", buf_addr, 0);
        check("t5_rst_tape_addr", tape_addr, 0);
        check("t5_rst_complete", tape_complete, 0);
        cycles(3);
        rst_n = 1'b1;
        cycles(2);
        base = lows.size();
        a0   = rd_addrs.size();
        pulse_start(2);
        verify_frame(base, 0, 0, mem[0]);
        verify_frame(base, 1, 1, mem[1]);
        wait_complete("t5");
        if (rd_addrs.size() > a0 + 1) begin
            check("t5_addr0", rd_addrs[a0], 0);
            check("t5_addr1", rd_addrs[a0 + 1], 1);
        end

        // remote dropped in the middle of the start cell's long low
        mem[0] = 8'($urandom);
        base   = lows.size();
        pulse_start(1);
        wait_level(1'b0, "t6_low");
        wait_ticks(5);
        remote = 1'b0;
        wait_ticks(100);
`ifdef TAP_REMOTE_GATE_EN
        check("t6_frozen_low", tape_out, 0);
        check("t6_frozen_busy", busy, 1);
`endif
        @(posedge clk); #1;
        remote = 1'b1;
        verify_frame(base, 0, 0, mem[0]);
        wait_complete("t6");

        check("fetch_addr_stable", unstable, 0);
        check("gap_tape_high", gap_low, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
